// File: rtl/pc_unit.sv
// Fetch program counter with next-PC select, fetch handshake,
// misalignment trap and a circular return-address stack.
module pc_unit #(
  parameter int            AW        = 32,
  parameter logic [AW-1:0] RESET_VEC = AW'(32'h0000_0000),
  parameter logic [AW-1:0] EXC_VEC   = AW'(32'h0000_0040),
  parameter int            INC       = 4,
  parameter int            RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i,
  input  logic          exc_i,
  input  logic          call_i,
  input  logic [AW-1:0] call_ret_i,
  input  logic          ret_i,
  input  logic          fetch_ready_i,
  output logic [AW-1:0] pc_o,
  output logic [AW-1:0] pca4_o,
  output logic          fetch_valid_o,
  output logic          misalign_o,
  output logic          ras_empty_o
);

  localparam int PW = $clog2(RAS_DEPTH);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_TRAP
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0] r_ptr;
  logic [PW:0]   r_cnt;

  logic          w_active;
  logic          w_run;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_seq;
  logic          w_jump;
  logic [PW-1:0] w_top_idx;
  logic [AW-1:0] w_top;
  logic [AW-1:0] w_pc_nxt;

  assign w_active  = (r_state != S_BOOT);
  assign w_run     = (r_state == S_RUN);
  assign w_empty   = (r_cnt == '0);
  assign w_jump    = exc_i | redirect_i;
  assign w_top_idx = r_ptr - PW'(1);
  assign w_top     = r_ras[w_top_idx];

  assign w_push = w_active & call_i & ~exc_i;
  assign w_pop  = w_run & ret_i & ~w_empty
                & ~exc_i & ~redirect_i;
  assign w_seq  = fetch_valid_o & fetch_ready_i
                & ~stall_i;

  assign pc_o          = r_pc;
  assign pca4_o        = r_pc + AW'(INC);
  assign misalign_o    = (r_pc[1:0] != 2'b00);
  assign fetch_valid_o = w_run & ~misalign_o;
  assign ras_empty_o   = w_empty;

  always_comb begin
    w_pc_nxt = r_pc;
    if (!w_active)       w_pc_nxt = r_pc;
    else if (exc_i)      w_pc_nxt = EXC_VEC;
    else if (redirect_i) w_pc_nxt = redirect_pc_i;
    else if (w_pop)      w_pc_nxt = w_top;
    else if (w_seq)      w_pc_nxt = r_pc + AW'(INC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_VEC;
    end else begin
      r_pc <= w_pc_nxt;
      unique case (r_state)
        S_BOOT: r_state <= S_RUN;
        S_RUN: begin
          if (w_jump)          r_state <= S_RUN;
          else if (misalign_o) r_state <= S_TRAP;
        end
        S_TRAP: begin
          if (w_jump) r_state <= S_RUN;
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  // Push+pop in one cycle rewrites the top in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++)
        r_ras[i] <= '0;
    end else if (w_active & exc_i) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_push & w_pop) begin
      r_ras[w_top_idx] <= call_ret_i;
    end else if (w_push) begin
      r_ras[r_ptr] <= call_ret_i;
      r_ptr        <= r_ptr + PW'(1);
      if (r_cnt != (PW+1)'(RAS_DEPTH))
        r_cnt <= r_cnt + (PW+1)'(1);
    end else if (w_pop) begin
      r_ptr <= r_ptr - PW'(1);
      r_cnt <= r_cnt - (PW+1)'(1);
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus queues expected state,
// a monitor compares it after each rising edge.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        exc_i = 1'b0;
  logic        call_i = 1'b0;
  logic [31:0] call_ret_i = '0;
  logic        ret_i = 1'b0;
  logic        fetch_ready_i = 1'b1;
  logic [31:0] pc_o;
  logic [31:0] pca4_o;
  logic        fetch_valid_o;
  logic        misalign_o;
  logic        ras_empty_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        v;
    logic        mis;
    logic        emp;
  } exp_t;

  exp_t q[$];

  pc_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .exc_i        (exc_i),
    .call_i       (call_i),
    .call_ret_i   (call_ret_i),
    .ret_i        (ret_i),
    .fetch_ready_i(fetch_ready_i),
    .pc_o         (pc_o),
    .pca4_o       (pca4_o),
    .fetch_valid_o(fetch_valid_o),
    .misalign_o   (misalign_o),
    .ras_empty_o  (ras_empty_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string n,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic push_exp(input string n, input logic [31:0] pc,
                          input logic v, input logic mis,
                          input logic emp);
    exp_t e;
    e.name = n;
    e.pc   = pc;
    e.v    = v;
    e.mis  = mis;
    e.emp  = emp;
    q.push_back(e);
  endtask

  task automatic cyc(input string n,
                     input logic st, input logic rd,
                     input logic [31:0] rpc, input logic ex,
                     input logic cl, input logic [31:0] cra,
                     input logic rt, input logic rdy,
                     input logic [31:0] epc, input logic ev,
                     input logic emis, input logic eemp);
    @(negedge clk);
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    exc_i         = ex;
    call_i        = cl;
    call_ret_i    = cra;
    ret_i         = rt;
    fetch_ready_i = rdy;
    push_exp(n, epc, ev, emis, eemp);
  endtask

  task automatic release_rst(input string n);
    @(negedge clk);
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    exc_i         = 1'b0;
    call_i        = 1'b0;
    ret_i         = 1'b0;
    fetch_ready_i = 1'b1;
    rst           = 1'b0;
    push_exp(n, 32'h0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.name, ".pc"}, pc_o, e.pc);
        check({e.name, ".pca4"}, pca4_o, e.pc + 32'd4);
        check({e.name, ".valid"}, 32'(fetch_valid_o), 32'(e.v));
        check({e.name, ".mis"}, 32'(misalign_o), 32'(e.mis));
        check({e.name, ".empty"}, 32'(ras_empty_o), 32'(e.emp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #1;
    check("rst.pc", pc_o, 32'h0);
    check("rst.valid", 32'(fetch_valid_o), 32'h0);
    check("rst.mis", 32'(misalign_o), 32'h0);
    check("rst.empty", 32'(ras_empty_o), 32'h1);
    @(negedge clk);
    @(negedge clk);
    check("boot.valid", 32'(fetch_valid_o), 32'h0);
    release_rst("boot");
    //   name     st rd rpc ex cl cra rt rdy  epc v mis emp
    cyc("seq1",  0,0,0,0,0,0,0,1, 32'h4, 1,0,1);
    cyc("seq2",  0,0,0,0,0,0,0,1, 32'h8, 1,0,1);
    cyc("stl1",  1,0,0,0,0,0,0,1, 32'h8, 1,0,1);
    cyc("stl2",  1,0,0,0,0,0,0,1, 32'h8, 1,0,1);
    cyc("stl3",  1,0,0,0,0,0,0,1, 32'h8, 1,0,1);
    cyc("nrdy1", 0,0,0,0,0,0,0,0, 32'h8, 1,0,1);
    cyc("nrdy2", 0,0,0,0,0,0,0,0, 32'h8, 1,0,1);
    cyc("seq3",  0,0,0,0,0,0,0,1, 32'hC, 1,0,1);
    cyc("seq4",  0,0,0,0,0,0,0,1, 32'h10, 1,0,1);
    cyc("call1", 0,0,0,0,1,32'h10,0,0, 32'h10, 1,0,0);
    cyc("call2", 0,0,0,0,1,32'h20,0,0, 32'h10, 1,0,0);
    cyc("call3", 0,0,0,0,1,32'h30,0,0, 32'h10, 1,0,0);
    cyc("call4", 0,0,0,0,1,32'h40,0,0, 32'h10, 1,0,0);
    cyc("call5", 0,0,0,0,1,32'h50,0,0, 32'h10, 1,0,0);
    cyc("redir", 1,1,32'h100,0,0,0,1,1, 32'h100, 1,0,0);
    cyc("ret1",  0,0,0,0,0,0,1,0, 32'h50, 1,0,0);
    cyc("ret2",  0,0,0,0,0,0,1,0, 32'h40, 1,0,0);
    cyc("ret3",  0,0,0,0,0,0,1,0, 32'h30, 1,0,0);
    cyc("ret4",  0,0,0,0,0,0,1,0, 32'h20, 1,0,1);
    cyc("ret5",  0,0,0,0,0,0,1,1, 32'h24, 1,0,1);
    cyc("cl6",   0,0,0,0,1,32'h80,0,0, 32'h24, 1,0,0);
    cyc("clrt",  0,0,0,0,1,32'h90,1,0, 32'h80, 1,0,0);
    cyc("ret6",  0,0,0,0,0,0,1,0, 32'h90, 1,0,1);
    cyc("cl7",   0,0,0,0,1,32'hA0,0,0, 32'h90, 1,0,0);
    cyc("mis1",  0,1,32'h102,0,0,0,0,1, 32'h102, 0,1,0);
    cyc("mis2",  0,0,0,0,0,0,0,1, 32'h102, 0,1,0);
    cyc("trap",  0,0,0,0,0,0,1,1, 32'h102, 0,1,0);
    cyc("exc",   0,0,0,1,1,32'hB0,0,1, 32'h40, 1,0,1);
    cyc("seq5",  0,0,0,0,0,0,0,1, 32'h44, 1,0,1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst.pc", pc_o, 32'h0);
    check("midrst.valid", 32'(fetch_valid_o), 32'h0);
    check("midrst.empty", 32'(ras_empty_o), 32'h1);
    release_rst("boot2");
    cyc("wrap0", 0,1,32'hFFFF_FFFC,0,0,0,0,1,
        32'hFFFF_FFFC, 1,0,1);
    cyc("wrap1", 0,0,0,0,0,0,0,1, 32'h0, 1,0,1);
    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the next fetch stage; successor of the single 32-bit PC register.
- Holds the fetch PC, selects the next PC (exception > redirect > return-address-stack pop > sequential), supports stall and a valid/ready fetch handshake, and flags misaligned PCs.
- Contains a DEPTH-entry return-address stack (RAS) for call/return prediction.
- Sits between the branch/exception logic (EX/MEM) and the instruction memory interface.

Parameters:
- AW, 32, PC/address width in bits (>= 8).
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- EXC_VEC, 32'h0000_0040, exception entry PC.
- INC, 4, sequential increment.
- RAS_DEPTH, 4, RAS entries (power of two, >= 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  hold PC (pipeline stall).
- redirect_i  in  1  branch/jump taken.
- redirect_pc_i  in  AW  redirect target.
- exc_i  in  1  exception/trap taken.
- call_i  in  1  push call_ret_i onto RAS.
- call_ret_i  in  AW  return address to push.
- ret_i  in  1  return: next PC from RAS top.
- fetch_ready_i  in  1  instruction memory accepts request.
- pc_o  out  AW  current fetch PC (registered).
- pca4_o  out  AW  pc_o + INC (combinational, wraps mod 2^AW).
- fetch_valid_o  out  1  fetch request valid (instruction-memory enable).
- misalign_o  out  1  pc_o[1:0] != 0.
- ras_empty_o  out  1  RAS holds no entries.

Behaviour:
- Reset (async, immediate): pc_o = RESET_VEC; FSM = BOOT; fetch_valid_o = 0; RAS count and pointer = 0; ras_empty_o = 1; misalign_o reflects RESET_VEC.
- Reset mid-operation discards all pending state; no redirect survives reset.
- FSM states:
  - BOOT: one cycle after rst deasserts; fetch_valid_o = 0; go to RUN.
  - RUN: fetch_valid_o = !misalign_o; go to TRAP when misalign_o = 1.
  - TRAP: fetch_valid_o = 0; hold PC; leave only on exc_i or redirect_i (to RUN, loading the new PC).
- Next-PC priority, evaluated each cycle in RUN/TRAP, PC updates on the next rising edge (1-cycle latency):
  1. exc_i: PC <= EXC_VEC. The RAS is flushed (count = 0) in the same edge; a simultaneous call_i is ignored.
  2. redirect_i: PC <= redirect_pc_i. Overrides stall and handshake. An outstanding unaccepted request is abandoned; fetch_addr may change while valid.
  3. ret_i with RAS non-empty: PC <= RAS top; pop.
     - ret_i with RAS empty: ignored, falls through to rule 4.
  4. fetch_valid_o & fetch_ready_i & !stall_i: PC <= PC + INC.
  5. Otherwise PC holds. A valid request with !ready keeps pc_o stable.
- In BOOT, PC holds regardless of inputs except rst.
- RAS:
  - Push writes call_ret_i at pointer, then increments the pointer mod RAS_DEPTH; count saturates at RAS_DEPTH.
  - Overflow overwrites the oldest entry (circular).
  - Pop decrements the pointer and count.
  - Push and pop in the same cycle replace the top entry; count is unchanged. The pop target is the old top.
  - Push and pop are acted on only when not masked by exc_i. Pop also requires that no redirect_i is present.
  - ras_empty_o = (count == 0), registered.
- Arithmetic: all PC sums are AW bits; carry discarded; 2^AW-INC + INC = 0.
- misalign_o is combinational from pc_o.

Test Plan:
- Reset then release, ready=1, no other inputs -> pc_o 0x0 (BOOT, valid=0), then valid=1, then 0x4, 0x8, 0xC on consecutive edges.
- stall_i high 3 cycles at pc 0x8, then fetch_ready_i low 2 cycles -> pc_o stays 0x8 for 5 cycles, then advances to 0xC.
- redirect_i=1 with target 0x100 together with stall_i=1 and ret_i=1 (RAS non-empty) -> pc_o = 0x100 next edge; RAS count unchanged.
- Five calls pushing 0x10, 0x20, 0x30, 0x40, 0x50 (RAS_DEPTH=4), then five rets -> PCs 0x50, 0x40, 0x30, 0x20; fifth ret ignored (PC+4); ras_empty_o = 1.
- Redirect to 0x102 -> misalign_o = 1, fetch_valid_o = 0, PC held; exc_i -> pc_o = 0x40, valid resumes; assert rst mid-stream -> pc_o = 0x0 immediately.
- PC = 0xFFFF_FFFC, ready=1 -> pc_o wraps to 0x0; pca4_o = 0x4.
